mmio_dmem: RTL and testbench

MMIO_DMEM -- requirements
Module: mmio_dmem

---
 rtl/mmio_pkg.sv | 51 +++++
 rtl/mmio_timer.sv | 59 +++++
 rtl/mmio_dmem.sv | 123 ++++++++++++
 tb/tb_mmio_dmem.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared MMIO address map, register bit positions and address decode helper.
package mmio_pkg;

  localparam logic [31:0] MMIO_BASE = 32'h0000_8000;

  // Byte offsets of the MMIO registers relative to MMIO_BASE.
  localparam logic [4:0] OFF_SW     = 5'h00;
  localparam logic [4:0] OFF_LED    = 5'h04;
  localparam logic [4:0] OFF_SEG    = 5'h08;
  localparam logic [4:0] OFF_TCOUNT = 5'h0C;
  localparam logic [4:0] OFF_TCMP   = 5'h10;
  localparam logic [4:0] OFF_STATUS = 5'h14;
  localparam logic [4:0] OFF_CTRL   = 5'h18;

  localparam int STAT_MATCH_BIT = 0;
  localparam int CTRL_TEN_BIT   = 0;
  localparam int CTRL_IEN_BIT   = 1;
  localparam int CTRL_W         = 2;

  typedef enum logic [2:0] {
    REG_SW,
    REG_LED,
    REG_SEG,
    REG_TCOUNT,
    REG_TCMP,
    REG_STATUS,
    REG_CTRL,
    REG_NONE
  } mmio_reg_e;

  // Map a byte address onto an MMIO register; anything outside the
  // 32-byte window at MMIO_BASE, or the unused slot at 0x801C, is REG_NONE.
  function automatic mmio_reg_e mmio_decode(input logic [31:0] a);
    mmio_reg_e r;
    r = REG_NONE;
    if (a[31:5] == MMIO_BASE[31:5]) begin
      case ({a[4:2], 2'b00})
        OFF_SW:     r = REG_SW;
        OFF_LED:    r = REG_LED;
        OFF_SEG:    r = REG_SEG;
        OFF_TCOUNT: r = REG_TCOUNT;
        OFF_TCMP:   r = REG_TCMP;
        OFF_STATUS: r = REG_STATUS;
        OFF_CTRL:   r = REG_CTRL;
        default:    r = REG_NONE;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// Free-running compare timer: TCOUNT, TCMP and the sticky match flag.
module mmio_timer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        wr_count_i,
  input  logic        wr_cmp_i,
  input  logic        clr_match_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] tcount_o,
  output logic [31:0] tcmp_o,
  output logic        match_o
);

  logic [31:0] tcount_q, tcount_d;
  logic [31:0] tcmp_q, tcmp_d;
  logic        match_q, match_d;
  logic        hit;

  // Next-state: CPU write beats increment/wrap; a match set beats a W1C clear.
  always_comb begin
    hit      = en_i && (tcount_q == tcmp_q);
    tcount_d = tcount_q;
    tcmp_d   = tcmp_q;
    match_d  = match_q;
    if (wr_count_i) begin
      tcount_d = wdata_i;
    end else if (en_i) begin
      tcount_d = hit ? 32'd0 : tcount_q + 32'd1;
    end
    if (wr_cmp_i) begin
      tcmp_d = wdata_i;
    end
    if (clr_match_i) begin
      match_d = 1'b0;
    end
    if (hit) begin
      match_d = 1'b1;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tcount_q <= '0;
      tcmp_q   <= '0;
      match_q  <= 1'b0;
    end else begin
      tcount_q <= tcount_d;
      tcmp_q   <= tcmp_d;
      match_q  <= match_d;
    end
  end

  assign tcount_o = tcount_q;
  assign tcmp_o   = tcmp_q;
  assign match_o  = match_q;

endmodule

// File: rtl/mmio_dmem.sv
// Data memory plus MMIO peripherals (switches, LEDs, 7-seg value, timer).
// RAM_WORDS must be a power of two between 32 and 8192 so the 5-bit debug
// index always lands inside the RAM.
module mmio_dmem
  import mmio_pkg::*;
#(
  parameter int RAM_WORDS = 256,
  parameter int SW_W      = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  input  logic            we,
  input  logic            re,
  output logic [31:0]     rdata,
  input  logic [SW_W-1:0] sw,
  output logic [SW_W-1:0] led,
  output logic [31:0]     seg_data,
  output logic            irq,
  input  logic [4:0]      dbg_addr,
  output logic [31:0]     dbg_data
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]       mem [RAM_WORDS];
  logic              ram_hit;
  logic [AW-1:0]     ram_idx;
  mmio_reg_e         sel;

  logic [31:0]       rdata_q, rdata_d;
  logic [SW_W-1:0]   led_q, led_d;
  logic [31:0]       seg_q, seg_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [SW_W-1:0]   sw_meta_q, sw_sync_q;

  logic [31:0]       tcount, tcmp;
  logic              match;
  logic [31:0]       rd_val;
  logic              unused_addr_lsbs;

  // Word accesses only; the byte lane bits carry no meaning here.
  assign unused_addr_lsbs = ^addr[1:0];

  // RAM occupies everything below 4*RAM_WORDS, which never overlaps MMIO.
  assign ram_hit = (addr[31:AW+2] == '0);
  assign ram_idx = addr[AW+1:2];
  assign sel     = mmio_decode(addr);

  // Read mux; values are taken before this edge's writes (read-before-write).
  always_comb begin
    rd_val = '0;
    if (ram_hit) begin
      rd_val = mem[ram_idx];
    end else begin
      case (sel)
        REG_SW:     rd_val = 32'(sw_sync_q);
        REG_LED:    rd_val = 32'(led_q);
        REG_SEG:    rd_val = seg_q;
        REG_TCOUNT: rd_val = tcount;
        REG_TCMP:   rd_val = tcmp;
        REG_STATUS: rd_val[STAT_MATCH_BIT] = match;
        REG_CTRL:   rd_val = 32'(ctrl_q);
        default:    rd_val = '0;
      endcase
    end
  end

  // Next-state for the load register and the plain RW registers.
  always_comb begin
    rdata_d = re ? rd_val : rdata_q;
    led_d   = (we && sel == REG_LED)  ? wdata[SW_W-1:0]   : led_q;
    seg_d   = (we && sel == REG_SEG)  ? wdata             : seg_q;
    ctrl_d  = (we && sel == REG_CTRL) ? wdata[CTRL_W-1:0] : ctrl_q;
  end

  // Resettable state, including the two-flop switch synchronizer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q   <= '0;
      led_q     <= '0;
      seg_q     <= '0;
      ctrl_q    <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      rdata_q   <= rdata_d;
      led_q     <= led_d;
      seg_q     <= seg_d;
      ctrl_q    <= ctrl_d;
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  // RAM keeps its contents through reset; stores during reset are dropped.
  always_ff @(posedge clk) begin
    if (!rst && we && ram_hit) begin
      mem[ram_idx] <= wdata;
    end
  end

  mmio_timer u_timer (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (ctrl_q[CTRL_TEN_BIT]),
    .wr_count_i  (we && sel == REG_TCOUNT),
    .wr_cmp_i    (we && sel == REG_TCMP),
    .clr_match_i (we && sel == REG_STATUS && wdata[STAT_MATCH_BIT]),
    .wdata_i     (wdata),
    .tcount_o    (tcount),
    .tcmp_o      (tcmp),
    .match_o     (match)
  );

  assign dbg_data = mem[AW'(dbg_addr)];
  assign rdata    = rdata_q;
  assign led      = led_q;
  assign seg_data = seg_q;
  assign irq      = match & ctrl_q[CTRL_IEN_BIT];

endmodule

// File: tb/tb_mmio_dmem.sv
// Bench for mmio_dmem: per-cycle comparison against a behavioural model of
// the memory map, plus directed literal expectations.
module tb_mmio_dmem;

  localparam int RAMW = 256;
  localparam int SWW  = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [31:0]     addr, wdata;
  logic            we, re;
  logic [SWW-1:0]  sw;
  logic [4:0]      dbg_addr;
  logic [31:0]     rdata, seg_data, dbg_data;
  logic [SWW-1:0]  led;
  logic            irq;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mmio_dmem #(.RAM_WORDS(RAMW), .SW_W(SWW)) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .wdata    (wdata),
    .we       (we),
    .re       (re),
    .rdata    (rdata),
    .sw       (sw),
    .led      (led),
    .seg_data (seg_data),
    .irq      (irq),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0]    m_ram [RAMW];
  bit             m_ram_v [RAMW];
  logic [31:0]    m_rdata, m_seg, m_tcount, m_tcmp;
  logic [SWW-1:0] m_led;
  logic [SWW-1:0] m_sw_hist [2];
  bit             m_status;
  logic [1:0]     m_ctrl;
  bit             m_rdata_known;
  bit             m_ok = 0;

  always @(posedge clk or posedge rst) begin
    logic [31:0] a, rd, nxt_count;
    bit          match, nxt_status, known;
    int          idx;
    if (rst) begin
      m_ok          = 1;
      m_rdata       = '0;
      m_rdata_known = 1;
      m_led         = '0;
      m_seg         = '0;
      m_tcount      = '0;
      m_tcmp        = '0;
      m_status      = 0;
      m_ctrl        = '0;
      m_sw_hist[0]  = '0;
      m_sw_hist[1]  = '0;
    end else if (m_ok) begin
      a     = addr & ~32'h3;
      idx   = int'(a >> 2);
      known = 1;
      rd    = '0;
      if (a < 4 * RAMW) begin
        rd    = m_ram[idx];
        known = m_ram_v[idx];
      end else begin
        case (a)
          32'h8000: rd = 32'(m_sw_hist[1]);
          32'h8004: rd = 32'(m_led);
          32'h8008: rd = m_seg;
          32'h800C: rd = m_tcount;
          32'h8010: rd = m_tcmp;
          32'h8014: rd = 32'(m_status);
          32'h8018: rd = 32'(m_ctrl);
          default:  rd = '0;
        endcase
      end
      match      = m_ctrl[0] && (m_tcount == m_tcmp);
      nxt_count  = !m_ctrl[0] ? m_tcount : (match ? 32'd0 : m_tcount + 32'd1);
      nxt_status = m_status;
      if (we) begin
        if (a < 4 * RAMW) begin
          m_ram[idx]   = wdata;
          m_ram_v[idx] = 1;
        end else begin
          case (a)
            32'h8004: m_led = wdata[SWW-1:0];
            32'h8008: m_seg = wdata;
            32'h800C: nxt_count = wdata;
            32'h8010: m_tcmp = wdata;
            32'h8014: if (wdata[0]) nxt_status = 0;
            32'h8018: m_ctrl = wdata[1:0];
            default: ;
          endcase
        end
      end
      if (match) nxt_status = 1;
      m_tcount = nxt_count;
      m_status = nxt_status;
      if (re) begin
        m_rdata       = rd;
        m_rdata_known = known;
      end
      m_sw_hist[1] = m_sw_hist[0];
      m_sw_hist[0] = sw;
    end
  end

  // Per-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (m_ok) begin
      if (m_rdata_known) chk("cyc_rdata", rdata, m_rdata);
      chk("cyc_led", 32'(led), 32'(m_led));
      chk("cyc_seg", seg_data, m_seg);
      chk("cyc_irq", 32'(irq), 32'(m_status & m_ctrl[1]));
      if (m_ram_v[dbg_addr]) chk("cyc_dbg", dbg_data, m_ram[dbg_addr]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic access(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
    we    = w;
    re    = r;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0;
    re = 1'b0;
  endtask

  localparam logic [31:0] TSEQ [5] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
  localparam bit          TIRQ [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    we = 0; re = 0; addr = '0; wdata = '0; sw = '0; dbg_addr = 5'd4;
    idle(3);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_seg", seg_data, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    rst = 1'b0;
    idle(1);

    // RAM store/load, debug port, size boundary
    access(1, 0, 32'h10, 32'hDEADBEEF);
    chk("dbg_after_store", dbg_data, 32'hDEADBEEF);
    access(0, 1, 32'h10, 0);
    chk("load_0x10", rdata, 32'hDEADBEEF);
    access(1, 0, 32'h0, 32'h11111111);
    access(1, 0, 32'h3FC, 32'h22222222);
    access(1, 0, 32'h400, 32'h33333333);
    access(0, 1, 32'h3FC, 0);
    chk("load_last_word", rdata, 32'h22222222);
    access(0, 1, 32'h400, 0);
    chk("load_above_ram", rdata, 32'h0);
    access(0, 1, 32'h0, 0);
    chk("load_word0", rdata, 32'h11111111);

    // Switches, LED, 7-seg
    sw = 8'hA5;
    idle(3);
    access(0, 1, 32'h8000, 0);
    chk("sw_read", rdata, 32'h000000A5);
    access(1, 0, 32'h8004, 32'h1FF);
    chk("led_write", 32'(led), 32'hFF);
    access(0, 1, 32'h8006, 0);
    chk("led_read", rdata, 32'h000000FF);
    access(1, 0, 32'h8008, 32'h12345678);
    chk("seg_write", seg_data, 32'h12345678);

    // Read-before-write and unmapped accesses
    access(1, 1, 32'h10, 32'h0BADF00D);
    chk("read_before_write", rdata, 32'hDEADBEEF);
    chk("dbg_new_value", dbg_data, 32'h0BADF00D);
    access(1, 0, 32'h10, 32'hDEADBEEF);
    access(1, 0, 32'h4000, 32'hFFFFFFFF);
    access(0, 1, 32'h4000, 0);
    chk("unmapped_read", rdata, 32'h0);
    chk("unmapped_led", 32'(led), 32'hFF);
    access(0, 1, 32'h0, 0);
    chk("unmapped_no_alias", rdata, 32'h11111111);
    access(0, 1, 32'h8008, 0);
    access(0, 1, 32'h801C, 0);
    chk("unmapped_mmio", rdata, 32'h0);

    // Timer sequence with TCMP=3
    access(1, 0, 32'h8010, 32'd3);
    access(1, 0, 32'h800C, 32'd0);
    access(1, 0, 32'h8018, 32'd3);
    for (int i = 0; i < 5; i++) begin
      access(0, 1, 32'h800C, 0);
      chk("tcount_seq", rdata, TSEQ[i]);
      chk("irq_seq", 32'(irq), 32'(TIRQ[i]));
    end
    access(1, 0, 32'h8014, 32'd1);
    chk("w1c_clears_irq", 32'(irq), 32'h0);
    idle(1);
    access(1, 0, 32'h8014, 32'd1);
    chk("set_beats_clear", 32'(irq), 32'h1);
    access(1, 0, 32'h800C, 32'h100);
    access(0, 1, 32'h800C, 0);
    chk("tcount_write_priority", rdata, 32'h100);
    access(1, 0, 32'h8018, 32'd0);
    access(1, 0, 32'h8014, 32'd1);

    // Reset mid-count with irq raised
    access(1, 0, 32'h800C, 32'd3);
    access(1, 0, 32'h8018, 32'd3);
    access(0, 1, 32'h8008, 0);
    chk("irq_before_rst", 32'(irq), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_irq", 32'(irq), 32'h0);
    chk("rst_async_led", 32'(led), 32'h0);
    chk("rst_async_seg", seg_data, 32'h0);
    chk("rst_async_rdata", rdata, 32'h0);
    access(1, 0, 32'h10, 32'h55555555);
    rst = 1'b0;
    idle(1);
    access(0, 1, 32'h800C, 0);
    chk("tcount_after_rst", rdata, 32'h0);
    access(0, 1, 32'h10, 0);
    chk("ram_survives_rst", rdata, 32'hDEADBEEF);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
